// File: rtl/zeroheti_irq_sched.sv
// zeroHETI interrupt priority scheduler: pending capture, per-line config,
// highest-priority arbitration and a hardware nesting-level stack.
module zeroheti_irq_sched #(
    parameter int unsigned NrIrqs = 32,
    parameter int unsigned NrPrio = 8,
    localparam int unsigned IrqWidth = $clog2(NrIrqs),
    localparam int unsigned PrioWidth = $clog2(NrPrio),
    localparam int unsigned StackDepth = NrPrio - 1,
    localparam int unsigned SpWidth = $clog2(StackDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NrIrqs-1:0]    ext_irqs_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [IrqWidth-1:0]  cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [31:0]          cfg_rdata_o,
    output logic                 irq_valid_o,
    output logic [IrqWidth-1:0]  irq_id_o,
    output logic [PrioWidth-1:0] irq_level_o,
    output logic                 irq_nest_o,
    input  logic [IrqWidth-1:0]  irq_id_i,
    input  logic                 irq_ack_i,
    input  logic                 irq_exit_i,
    output logic                 stack_err_o
);

    logic [NrIrqs-1:0]    r_irq_q;
    logic [NrIrqs-1:0]    r_irq_prev_q;
    logic [NrIrqs-1:0]    r_ie;
    logic [NrIrqs-1:0]    r_ip;
    logic [NrIrqs-1:0]    r_edge;
    logic [PrioWidth-1:0] r_prio [NrIrqs];
    logic [PrioWidth-1:0] r_stack [StackDepth];
    logic [SpWidth-1:0]   r_sp;
    logic                 r_err;
    logic                 r_rvalid;
    logic [31:0]          r_rdata;
    logic                 r_valid;
    logic [IrqWidth-1:0]  r_id;
    logic [PrioWidth-1:0] r_level;
    logic                 r_nest;

    logic [NrIrqs-1:0]    w_hw_set;
    logic [NrIrqs-1:0]    w_wr_sel;
    logic [NrIrqs-1:0]    w_ack_sel;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_addr_ok;
    logic                 w_ack_ok;
    logic [31:0]          w_rword;
    logic [PrioWidth-1:0] w_thr;
    logic [PrioWidth-1:0] w_ack_prio;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_err;
    logic [SpWidth-1:0]   w_sp_pop;
    logic                 w_win;
    logic [IrqWidth-1:0]  w_win_id;
    logic [PrioWidth-1:0] w_win_prio;

    assign cfg_gnt_o    = cfg_req_i;
    assign cfg_rvalid_o = r_rvalid;
    assign cfg_rdata_o  = r_rdata;
    assign irq_valid_o  = r_valid;
    assign irq_id_o     = r_id;
    assign irq_level_o  = r_level;
    assign irq_nest_o   = r_nest;
    assign stack_err_o  = r_err;

    // Edge lines pend on a 0->1 of the captured input, level lines while high.
    assign w_hw_set  = r_irq_q & (~r_edge | ~r_irq_prev_q);
    assign w_wr      = cfg_req_i & cfg_we_i;
    assign w_rd      = cfg_req_i & ~cfg_we_i;
    assign w_addr_ok = (32'(cfg_addr_i) < NrIrqs);
    assign w_ack_ok  = (32'(irq_id_i) < NrIrqs);

    always_comb begin
        w_wr_sel  = '0;
        w_ack_sel = '0;
        for (int i = 0; i < int'(NrIrqs); i++) begin
            w_wr_sel[i]  = w_wr & (cfg_addr_i == IrqWidth'(i));
            w_ack_sel[i] = irq_ack_i & (irq_id_i == IrqWidth'(i));
        end
    end

    always_comb begin
        w_rword = '0;
        if (w_addr_ok) begin
            w_rword[0]              = r_ie[cfg_addr_i];
            w_rword[1]              = r_ip[cfg_addr_i];
            w_rword[2]              = r_edge[cfg_addr_i];
            w_rword[8+:PrioWidth]   = r_prio[cfg_addr_i];
        end
    end

    always_comb begin
        w_ack_prio = '0;
        if (w_ack_ok) begin
            w_ack_prio = r_prio[irq_id_i];
        end
    end

    assign w_thr = (r_sp == '0) ? '0 : r_stack[r_sp - 1'b1];

    // Exit pops before ack pushes, so a same-cycle pair replaces the top.
    assign w_pop    = irq_exit_i & (r_sp != '0);
    assign w_sp_pop = r_sp - SpWidth'(w_pop);
    assign w_push   = irq_ack_i & (w_sp_pop != SpWidth'(StackDepth));
    assign w_err    = (irq_exit_i & (r_sp == '0)) | (irq_ack_i & ~w_push);

    // Strict compare keeps the lowest ID on equal priority.
    always_comb begin
        w_win      = 1'b0;
        w_win_id   = '0;
        w_win_prio = '0;
        for (int i = 0; i < int'(NrIrqs); i++) begin
            if (r_ip[i] && r_ie[i] && (r_prio[i] > w_thr) &&
                (r_prio[i] > w_win_prio)) begin
                w_win      = 1'b1;
                w_win_id   = IrqWidth'(i);
                w_win_prio = r_prio[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_q      <= '0;
            r_irq_prev_q <= '0;
        end else begin
            r_irq_q      <= ext_irqs_i;
            r_irq_prev_q <= r_irq_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ie   <= '0;
            r_ip   <= '0;
            r_edge <= '0;
            for (int i = 0; i < int'(NrIrqs); i++) begin
                r_prio[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NrIrqs); i++) begin
                if (w_hw_set[i]) begin
                    r_ip[i] <= 1'b1;
                end else if (w_wr_sel[i]) begin
                    r_ip[i] <= cfg_wdata_i[1];
                end else if (w_ack_sel[i]) begin
                    r_ip[i] <= 1'b0;
                end
                if (w_wr_sel[i]) begin
                    r_ie[i]   <= cfg_wdata_i[0];
                    r_edge[i] <= cfg_wdata_i[2];
                    r_prio[i] <= cfg_wdata_i[8+:PrioWidth];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sp  <= '0;
            r_err <= 1'b0;
            for (int i = 0; i < int'(StackDepth); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_sp  <= w_sp_pop + SpWidth'(w_push);
            r_err <= r_err | w_err;
            if (w_push) begin
                r_stack[w_sp_pop] <= w_ack_prio;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= cfg_req_i;
            r_rdata  <= w_rd ? w_rword : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_level <= '0;
            r_nest  <= 1'b0;
        end else if (irq_ack_i) begin
            r_valid <= 1'b0;
        end else if (w_win) begin
            r_valid <= 1'b1;
            r_id    <= w_win_id;
            r_level <= w_win_prio;
            r_nest  <= (r_sp != '0);
        end else begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zeroheti_irq_sched.sv
// Directed self-checking bench for zeroheti_irq_sched.
// Steps run in one initial block; expected values are hand-derived.
module tb_zeroheti_irq_sched;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] ext_irqs_i;
    logic        cfg_req_i;
    logic        cfg_we_i;
    logic [4:0]  cfg_addr_i;
    logic [31:0] cfg_wdata_i;
    logic        cfg_gnt_o;
    logic        cfg_rvalid_o;
    logic [31:0] cfg_rdata_o;
    logic        irq_valid_o;
    logic [4:0]  irq_id_o;
    logic [2:0]  irq_level_o;
    logic        irq_nest_o;
    logic [4:0]  irq_id_i;
    logic        irq_ack_i;
    logic        irq_exit_i;
    logic        stack_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    zeroheti_irq_sched dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ext_irqs_i   (ext_irqs_i),
        .cfg_req_i    (cfg_req_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_gnt_o    (cfg_gnt_o),
        .cfg_rvalid_o (cfg_rvalid_o),
        .cfg_rdata_o  (cfg_rdata_o),
        .irq_valid_o  (irq_valid_o),
        .irq_id_o     (irq_id_o),
        .irq_level_o  (irq_level_o),
        .irq_nest_o   (irq_nest_o),
        .irq_id_i     (irq_id_i),
        .irq_ack_i    (irq_ack_i),
        .irq_exit_i   (irq_exit_i),
        .stack_err_o  (stack_err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        cfg_req_i   = 1'b1;
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        tick();
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
        cfg_wdata_i = '0;
    endtask

    task automatic cfg_rd(input string tag, input logic [4:0] a,
                          input logic [31:0] exp);
        cfg_req_i  = 1'b1;
        cfg_we_i   = 1'b0;
        cfg_addr_i = a;
        #1;
        chk({tag, "_gnt"}, 32'(cfg_gnt_o), 32'd1);
        tick();
        cfg_req_i = 1'b0;
        chk({tag, "_rvalid"}, 32'(cfg_rvalid_o), 32'd1);
        chk(tag, cfg_rdata_o, exp);
    endtask

    task automatic ack(input logic [4:0] id);
        irq_id_i  = id;
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic do_exit();
        irq_exit_i = 1'b1;
        tick();
        irq_exit_i = 1'b0;
    endtask

    task automatic chk_req(input string tag, input logic v,
                           input logic [4:0] id, input logic [2:0] lv,
                           input logic nest);
        chk({tag, "_valid"}, 32'(irq_valid_o), 32'(v));
        chk({tag, "_id"}, 32'(irq_id_o), 32'(id));
        chk({tag, "_level"}, 32'(irq_level_o), 32'(lv));
        chk({tag, "_nest"}, 32'(irq_nest_o), 32'(nest));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        rst_ni      = 1'b0;
        ext_irqs_i  = '0;
        cfg_req_i   = 1'b0;
        cfg_we_i    = 1'b0;
        cfg_addr_i  = '0;
        cfg_wdata_i = '0;
        irq_id_i    = '0;
        irq_ack_i   = 1'b0;
        irq_exit_i  = 1'b0;
        repeat (3) tick();

        chk_req("rst", 1'b0, 5'd0, 3'd0, 1'b0);
        chk("rst_err", 32'(stack_err_o), 32'd0);
        chk("rst_rvalid", 32'(cfg_rvalid_o), 32'd0);
        chk("rst_rdata", cfg_rdata_o, 32'd0);
        chk("rst_gnt", 32'(cfg_gnt_o), 32'd0);
        rst_ni = 1'b1;
        tick();

        // basic edge request, unused bits masked on write
        cfg_wr(5'd5, 32'hFFFF_F305);
        chk("wr_rvalid", 32'(cfg_rvalid_o), 32'd1);
        chk("wr_rdata", cfg_rdata_o, 32'd0);
        cfg_rd("rd5", 5'd5, 32'h0000_0305);
        ext_irqs_i[5] = 1'b1;
        tick();
        ext_irqs_i[5] = 1'b0;
        tick();
        chk("edge_early", 32'(irq_valid_o), 32'd0);
        tick();
        chk_req("edge5", 1'b1, 5'd5, 3'd3, 1'b0);
        ack(5'd5);
        chk("ack5_valid", 32'(irq_valid_o), 32'd0);
        chk("ack5_sp", 32'(dut.r_sp), 32'd1);
        do_exit();
        chk("exit5_sp", 32'(dut.r_sp), 32'd0);
        chk("exit5_err", 32'(stack_err_o), 32'd0);

        // arbitration: 7 beats 2, ties 7 vs 9 go to 7
        cfg_wr(5'd2, 32'h0000_0403);
        cfg_wr(5'd7, 32'h0000_0603);
        cfg_wr(5'd9, 32'h0000_0603);
        tick();
        chk_req("arb7", 1'b1, 5'd7, 3'd6, 1'b0);
        ack(5'd7);
        tick();
        tick();
        chk("arb_thr_block", 32'(irq_valid_o), 32'd0);
        do_exit();
        chk("arb_exit_n1", 32'(irq_valid_o), 32'd0);
        tick();
        chk_req("arb9", 1'b1, 5'd9, 3'd6, 1'b0);
        ack(5'd9);
        do_exit();
        tick();
        chk_req("arb2", 1'b1, 5'd2, 3'd4, 1'b0);
        ack(5'd2);
        do_exit();

        // nesting
        cfg_wr(5'd1, 32'h0000_0203);
        tick();
        chk_req("nest1", 1'b1, 5'd1, 3'd2, 1'b0);
        ack(5'd1);
        cfg_wr(5'd4, 32'h0000_0503);
        tick();
        chk_req("nest4", 1'b1, 5'd4, 3'd5, 1'b1);
        ack(5'd4);
        chk("nest_sp2", 32'(dut.r_sp), 32'd2);
        do_exit();
        do_exit();
        chk("nest_sp0", 32'(dut.r_sp), 32'd0);
        chk("nest_err", 32'(stack_err_o), 32'd0);

        // level re-pend
        cfg_wr(5'd3, 32'h0000_0301);
        ext_irqs_i[3] = 1'b1;
        tick();
        tick();
        tick();
        chk_req("lvl3", 1'b1, 5'd3, 3'd3, 1'b0);
        ack(5'd3);
        chk("lvl_ack_valid", 32'(irq_valid_o), 32'd0);
        cfg_rd("lvl_repend", 5'd3, 32'h0000_0303);
        chk("lvl_blocked", 32'(irq_valid_o), 32'd0);
        do_exit();
        chk("lvl_exit_n1", 32'(irq_valid_o), 32'd0);
        tick();
        chk_req("lvl_again", 1'b1, 5'd3, 3'd3, 1'b0);
        ext_irqs_i[3] = 1'b0;
        tick();
        ack(5'd3);
        do_exit();
        cfg_wr(5'd3, 32'h0);

        // stack full
        for (int k = 0; k < 8; k++) begin
            cfg_wr(5'(10 + k), 32'((k < 7 ? k + 1 : 7) << 8));
        end
        for (int k = 0; k < 7; k++) begin
            ack(5'(10 + k));
        end
        chk("full_sp", 32'(dut.r_sp), 32'd7);
        chk("full_err0", 32'(stack_err_o), 32'd0);
        ack(5'd17);
        chk("over_err", 32'(stack_err_o), 32'd1);
        chk("over_sp", 32'(dut.r_sp), 32'd7);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("stack%0d", k), 32'(dut.r_stack[k]), 32'(k + 1));
        end
        chk("full_novalid", 32'(irq_valid_o), 32'd0);

        // async reset clears sticky error
        rst_ni = 1'b0;
        #2;
        chk("arst_err", 32'(stack_err_o), 32'd0);
        chk("arst_sp", 32'(dut.r_sp), 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        // empty exit
        do_exit();
        chk("under_err", 32'(stack_err_o), 32'd1);
        chk("under_sp", 32'(dut.r_sp), 32'd0);
        do_reset();

        // ack + exit same cycle
        cfg_wr(5'd10, 32'h0000_0200);
        cfg_wr(5'd11, 32'h0000_0500);
        ack(5'd10);
        ack(5'd10);
        irq_id_i   = 5'd11;
        irq_ack_i  = 1'b1;
        irq_exit_i = 1'b1;
        tick();
        irq_ack_i  = 1'b0;
        irq_exit_i = 1'b0;
        chk("sim_sp", 32'(dut.r_sp), 32'd2);
        chk("sim_top", 32'(dut.r_stack[1]), 32'd5);
        chk("sim_bot", 32'(dut.r_stack[0]), 32'd2);
        chk("sim_err", 32'(stack_err_o), 32'd0);

        // hw edge beats sw clear of ip
        cfg_wr(5'd6, 32'h0000_0104);
        ext_irqs_i[6] = 1'b1;
        tick();
        cfg_wr(5'd6, 32'h0000_0104);
        cfg_rd("hw_vs_sw", 5'd6, 32'h0000_0106);

        // mid-operation async reset
        cfg_wr(5'd20, 32'h0000_0703);
        tick();
        chk_req("pre_rst", 1'b1, 5'd20, 3'd7, 1'b1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_req("mid_rst", 1'b0, 5'd0, 3'd0, 1'b0);
        chk("mid_rst_sp", 32'(dut.r_sp), 32'd0);
        chk("mid_rst_err", 32'(stack_err_o), 32'd0);
        chk("mid_rst_rvalid", 32'(cfg_rvalid_o), 32'd0);
        chk("mid_rst_rdata", cfg_rdata_o, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/zeroheti_irq_sched.md
# zeroheti_irq_sched

Priority scheduler between the external interrupt lines and the zeroHETI core. It latches pending requests, holds per-line enable/trigger/priority configuration, selects the highest-priority eligible line, and tracks the nesting level of interrupts in service with a hardware level stack. Configuration is reached through a simple single-cycle register port that an OBI adapter fronts. The block presents one request at a time to the core's `irq_valid_o`/`irq_ack_i` handshake.

## Interface
- `NrIrqs`, default 32: number of external interrupt lines; line IDs are `0..NrIrqs-1`.
- `NrPrio`, default 8: number of priority levels; level 0 means "never interrupts".
- `IrqWidth`, localparam `$clog2(NrIrqs)`.
- `PrioWidth`, localparam `$clog2(NrPrio)`.
- `StackDepth`, localparam `NrPrio-1`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Decided: one clock; reset is asynchronous and active-low.
- `ext_irqs_i` in NrIrqs: raw interrupt lines, synchronous to `clk_i`.
- `cfg_req_i` in 1: config access request.
- `cfg_we_i` in 1: 1 = write, 0 = read.
- `cfg_addr_i` in IrqWidth: line index.
- `cfg_wdata_i` in 32: write data.
- `cfg_gnt_o` out 1: grant; equals `cfg_req_i`, combinational.
- `cfg_rvalid_o` out 1: response valid one cycle after a granted access, for reads and writes.
- `cfg_rdata_o` out 32: read data; 0 for writes.
- `irq_valid_o` out 1: request to the core.
- `irq_id_o` out IrqWidth: ID of the requested line.
- `irq_level_o` out PrioWidth: priority of the requested line.
- `irq_nest_o` out 1: the request preempts an interrupt already in service.
- `irq_id_i` in IrqWidth: ID the core is taking.
- `irq_ack_i` in 1: the core takes `irq_id_i` (single-cycle pulse).
- `irq_exit_i` in 1: the core returns from the current handler (single-cycle pulse).
- `stack_err_o` out 1: sticky; an ack arrived while the stack was full, or an exit arrived while it was empty.

## Operation
Per-line config word, one per line:
- bit0 `ie`: enable.
- bit1 `ip`: pending. Writable by software.
- bit2 `edge`: 1 = rising-edge trigger, 0 = level trigger.
- bits `[8+:PrioWidth]`: `prio`.
- All other bits read 0 and ignore writes.

Input capture:
- `ext_irqs_i` is registered into `irq_q` every cycle.
- Edge lines set `ip` when `irq_q & ~irq_prev_q`.
- Level lines set `ip` whenever `irq_q` is 1.

Pending update priority, per line per cycle:
1. Hardware set.
2. Software write.
3. Ack clear.

Arbitration (combinational):
- Candidates are lines with `ip & ie & (prio > thr)`.
- `thr` is the level on top of the stack, or 0 when the stack is empty.
- The winner is the candidate with the highest `prio`. Ties go to the lowest ID.

Output register:
- `irq_valid_o`, `irq_id_o` and `irq_level_o` are the registered winner.
- `irq_nest_o` is registered as winner valid AND stack non-empty.
- When there is no winner, `irq_valid_o` = 0 and the other request outputs hold their last values.

Ack:
- On `irq_ack_i`, clear `ip[irq_id_i]` and push `prio[irq_id_i]`.
- If the stack is full, do not push and set `stack_err_o`. The `ip` clear still happens.
- A level line that is still asserted re-pends on the next capture.
- `irq_valid_o` is forced to 0 in the cycle after an ack.

Exit:
- On `irq_exit_i`, pop the stack.
- If the stack is empty, ignore the exit and set `stack_err_o`.
- If `irq_ack_i` and `irq_exit_i` arrive in the same cycle, the exit pops first and the ack then pushes: the top entry is replaced and depth is unchanged.

Stack:
- Storage is a register array plus a pointer of width `$clog2(StackDepth+1)`.

Reset:
- Every output is 0.
- All config words are 0: disabled, level trigger, `prio` 0.
- Stack is empty, `irq_q` and `irq_prev_q` are 0, `stack_err_o` is 0.

## Timing
- Line edge at cycle N: `irq_q` updates at N+1, `ip` at N+2, `irq_valid_o` high at N+3.
- Software write of `ip`/`ie`/`prio` in cycle N: the register updates at N+1, and `irq_valid_o` reflects it at N+2.
- A read in cycle N returns the config word on `cfg_rdata_o` with `cfg_rvalid_o` at N+1.
- Ack in cycle N:
  - `irq_valid_o` = 0 at N+1.
  - The new threshold takes effect in arbitration at N+1.
  - The next request can appear at N+2.
- Exit in cycle N: the lowered threshold applies in arbitration at N+1, so a request can appear at N+2.
- `irq_valid_o` may drop without an ack if the line's `ie` or `ip` is cleared by software. The core must sample `irq_id_o` in the cycle it asserts `irq_ack_i`.

## Test plan
- Basic edge request:
  - Stimulus: line 5 configured edge, `ie`, `prio` 3. Pulse `ext_irqs_i[5]`.
  - Response: `irq_valid_o` high 3 cycles later with id 5, level 3, nest 0. Ack makes valid 0 and stack depth 1. Exit returns depth to 0.
- Arbitration:
  - Stimulus: lines 2, 7 and 9 pending with prio 4, 6 and 6.
  - Response: id 7 first. After acking 7, no request is issued until exit, because 9 has prio 6 and does not exceed threshold 6. After exit, id 9 with nest 0.
- Nesting:
  - Stimulus: ack line 1 (prio 2). Then line 4 (prio 5) pends.
  - Response: id 4 with nest 1. Ack gives stack depth 2. Exit, exit: depth 0, `stack_err_o` stays 0.
- Level re-pend:
  - Stimulus: line 3 level-triggered, held high. Ack it, then exit.
  - Response: `ip[3]` is set again. After the exit, the request for id 3 reappears 2 cycles later.
- Stack boundaries:
  - Stimulus: 7 acks with prio 1..7, then an 8th ack; separately, an exit with an empty stack.
  - Response: the 8th ack sets `stack_err_o` and the stack holds [1..7]. The empty exit sets `stack_err_o` and depth stays 0.
- Simultaneous events and mid-operation reset:
  - Stimulus A: ack and exit in the same cycle. Response: depth unchanged, top entry equals the acked prio.
  - Stimulus B: hardware edge and software clear of `ip` in the same cycle. Response: `ip` = 1.
  - Stimulus C: `rst_ni` low while a request is valid and the stack depth is 2. Response: all outputs 0 and the stack is empty, both asynchronously.
